// File: rtl/axil_gpio_pkg.sv
// Shared definitions for axil_gpio_slave: register offsets (ADDR[3:2]),
// AXI response codes and the write/read FSM state types.
package axil_gpio_pkg;
   localparam logic [1:0] REG_OUT = 2'd0;
   localparam logic [1:0] REG_IN  = 2'd1;
   localparam logic [1:0] REG_SET = 2'd2;
   localparam logic [1:0] REG_CLR = 2'd3;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic {W_IDLE, W_RESP} wr_state_t;
   typedef enum logic {R_IDLE, R_DATA} rd_state_t;
endpackage

// File: rtl/gpio_sync.sv
// Register chain for asynchronous GPIO pins; STAGES=1 is a plain sample
// register, STAGES>=2 a metastability synchronizer.
module gpio_sync #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);
   logic [STAGES-1:0][WIDTH-1:0] r_stage;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_stage <= '0;
      end else begin
         r_stage[0] <= i_d;
         for (int i = 1; i < STAGES; i++) r_stage[i] <= r_stage[i-1];
      end
   end

   assign o_q = r_stage[STAGES-1];
endmodule

// File: rtl/axil_gpio_slave.sv
// AXI4-Lite GPIO slave: OUT/IN/SET/CLR registers with independent AW/W capture.
// Define GPIO_INPUT_SYNC_EN for a 2-flop pin synchronizer (default: 1 sample flop).
module axil_gpio_slave
   import axil_gpio_pkg::*;
#(
   parameter int          C_S_AXI_DATA_WIDTH = 32,
   parameter int          C_S_AXI_ADDR_WIDTH = 9,
   parameter logic [31:0] C_GPIO_RESET       = 32'h0
) (
   input  logic                            S_AXI_ACLK,
   input  logic                            S_AXI_ARESET,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   gpio_io_o,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   gpio_io_i
);
   localparam int AW = C_S_AXI_ADDR_WIDTH;
   localparam int DW = C_S_AXI_DATA_WIDTH;
`ifdef GPIO_INPUT_SYNC_EN
   localparam int SYNC_STAGES = 2;
`else
   localparam int SYNC_STAGES = 1;
`endif

   wr_state_t         r_wstate;
   rd_state_t         r_rstate;
   logic              r_awready, r_wready, r_bvalid, r_aw_held, r_w_held;
   logic [1:0]        r_bresp, r_rresp;
   logic [AW-3:0]     r_aw_word, r_ar_word;
   logic [DW-1:0]     r_wdata, r_rdata, r_out;
   logic [DW/8-1:0]   r_wstrb;
   logic              r_arready, r_rvalid;
   logic [DW-1:0]     w_in, w_mask, w_bits, w_rd_data;
   logic              w_aw_unmapped, w_ar_unmapped;
   logic              w_unused;

   // Byte lanes within a word are don't-care for the register decode.
   assign w_unused = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

   gpio_sync #(.WIDTH(DW), .STAGES(SYNC_STAGES)) u_sync (
      .i_clk (S_AXI_ACLK),
      .i_rst (S_AXI_ARESET),
      .i_d   (gpio_io_i),
      .o_q   (w_in)
   );

   always_comb begin
      w_mask = '0;
      for (int i = 0; i < DW/8; i++) w_mask[i*8 +: 8] = {8{r_wstrb[i]}};
   end

   assign w_bits        = r_wdata & w_mask;
   assign w_aw_unmapped = (r_aw_word >> 2) != '0;
   assign w_ar_unmapped = (r_ar_word >> 2) != '0;

   always_comb begin
      w_rd_data = '0;
      case (r_ar_word[1:0])
         REG_OUT: w_rd_data = r_out;
         REG_IN:  w_rd_data = w_in;
         default: w_rd_data = '0;
      endcase
   end

   // Write path: address and data latch independently, commit one edge later.
   always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
      if (S_AXI_ARESET) begin
         r_wstate  <= W_IDLE;
         r_awready <= 1'b0;
         r_wready  <= 1'b0;
         r_aw_held <= 1'b0;
         r_w_held  <= 1'b0;
         r_aw_word <= '0;
         r_wdata   <= '0;
         r_wstrb   <= '0;
         r_bvalid  <= 1'b0;
         r_bresp   <= RESP_OKAY;
         r_out     <= C_GPIO_RESET[DW-1:0];
      end else begin
         case (r_wstate)
            W_IDLE: begin
               if (r_aw_held && r_w_held) begin
                  r_aw_held <= 1'b0;
                  r_w_held  <= 1'b0;
                  r_bvalid  <= 1'b1;
                  r_wstate  <= W_RESP;
                  if (w_aw_unmapped) begin
                     r_bresp <= RESP_SLVERR;
                  end else begin
                     r_bresp <= RESP_OKAY;
                     case (r_aw_word[1:0])
                        REG_OUT: r_out <= (r_out & ~w_mask) | w_bits;
                        REG_SET: r_out <= r_out | w_bits;
                        REG_CLR: r_out <= r_out & ~w_bits;
                        default: ;
                     endcase
                  end
               end else begin
                  if (r_awready && S_AXI_AWVALID) begin
                     r_aw_word <= S_AXI_AWADDR[AW-1:2];
                     r_aw_held <= 1'b1;
                     r_awready <= 1'b0;
                  end else if (!r_aw_held) begin
                     r_awready <= 1'b1;
                  end
                  if (r_wready && S_AXI_WVALID) begin
                     r_wdata  <= S_AXI_WDATA;
                     r_wstrb  <= S_AXI_WSTRB;
                     r_w_held <= 1'b1;
                     r_wready <= 1'b0;
                  end else if (!r_w_held) begin
                     r_wready <= 1'b1;
                  end
               end
            end
            W_RESP: begin
               if (S_AXI_BREADY) begin
                  r_bvalid  <= 1'b0;
                  r_awready <= 1'b1;
                  r_wready  <= 1'b1;
                  r_wstate  <= W_IDLE;
               end
            end
            default: r_wstate <= W_IDLE;
         endcase
      end
   end

   always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
      if (S_AXI_ARESET) begin
         r_rstate  <= R_IDLE;
         r_arready <= 1'b0;
         r_ar_word <= '0;
         r_rvalid  <= 1'b0;
         r_rresp   <= RESP_OKAY;
         r_rdata   <= '0;
      end else begin
         case (r_rstate)
            R_IDLE: begin
               if (r_arready && S_AXI_ARVALID) begin
                  r_ar_word <= S_AXI_ARADDR[AW-1:2];
                  r_arready <= 1'b0;
                  r_rstate  <= R_DATA;
               end else begin
                  r_arready <= 1'b1;
               end
            end
            R_DATA: begin
               if (!r_rvalid) begin
                  r_rvalid <= 1'b1;
                  r_rresp  <= w_ar_unmapped ? RESP_SLVERR : RESP_OKAY;
                  r_rdata  <= w_ar_unmapped ? '0 : w_rd_data;
               end else if (S_AXI_RREADY) begin
                  r_rvalid  <= 1'b0;
                  r_arready <= 1'b1;
                  r_rstate  <= R_IDLE;
               end
            end
            default: r_rstate <= R_IDLE;
         endcase
      end
   end

   assign S_AXI_AWREADY = r_awready;
   assign S_AXI_WREADY  = r_wready;
   assign S_AXI_BVALID  = r_bvalid;
   assign S_AXI_BRESP   = r_bresp;
   assign S_AXI_ARREADY = r_arready;
   assign S_AXI_RVALID  = r_rvalid;
   assign S_AXI_RRESP   = r_rresp;
   assign S_AXI_RDATA   = r_rdata;
   assign gpio_io_o     = r_out;
endmodule

// File: tb/tb_axil_gpio_slave.sv
// Scoreboard bench for axil_gpio_slave: directed scenarios plus randomized
// register traffic checked against a behavioural register-map model.
module tb_axil_gpio_slave;
   typedef struct packed {
      logic [1:0]  resp;
      logic [31:0] data;
   } rsp_t;

   logic        clk = 1'b0;
   logic        S_AXI_ARESET;
   logic [8:0]  S_AXI_AWADDR, S_AXI_ARADDR;
   logic        S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WVALID, S_AXI_WREADY;
   logic [31:0] S_AXI_WDATA, S_AXI_RDATA;
   logic [3:0]  S_AXI_WSTRB;
   logic [1:0]  S_AXI_BRESP, S_AXI_RRESP;
   logic        S_AXI_BVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARREADY;
   logic        S_AXI_RVALID, S_AXI_RREADY;
   logic [31:0] gpio_io_o, gpio_io_i;

   int   n_tests = 0;
   int   n_fail  = 0;
   rsp_t bq[$];
   rsp_t rq[$];
   logic [31:0] m_out  = 32'h0;
   logic [31:0] m_pins = 32'h0;

   always #5 clk = ~clk;

   axil_gpio_slave dut (
      .S_AXI_ACLK(clk), .S_AXI_ARESET(S_AXI_ARESET),
      .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
      .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
      .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
      .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID),
      .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
      .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
      .gpio_io_o(gpio_io_o), .gpio_io_i(gpio_io_i)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: got timeout/extra response, required a single timely response", name);
   endtask

   // Register-map reference: decoded from the address, applied with byte masks.
   function automatic logic [1:0] model_write(input logic [8:0] a, input logic [31:0] d,
                                              input logic [3:0] s);
      logic [31:0] m;
      for (int i = 0; i < 4; i++) m[8*i +: 8] = s[i] ? 8'hFF : 8'h00;
      if (a > 9'h00F) return 2'b10;
      case (a[3:2])
         2'd0:    m_out = (m_out & ~m) | (d & m);
         2'd2:    m_out = m_out | (d & m);
         2'd3:    m_out = m_out & ~(d & m);
         default: ;
      endcase
      return 2'b00;
   endfunction

   function automatic rsp_t model_read(input logic [8:0] a);
      rsp_t r;
      r.resp = 2'b00;
      r.data = 32'h0;
      if (a > 9'h00F) r.resp = 2'b10;
      else if (a[3:2] == 2'd0) r.data = m_out;
      else if (a[3:2] == 2'd1) r.data = m_pins;
      return r;
   endfunction

   // Monitor: pops one expectation per completed B or R handshake.
   initial begin
      rsp_t e;
      forever begin
         @(negedge clk);
         if (S_AXI_ARESET !== 1'b1) begin
            if (S_AXI_BVALID && S_AXI_BREADY) begin
               if (bq.size() == 0) fail_now("unexpected_B");
               else begin
                  e = bq.pop_front();
                  chk("BRESP", 32'(S_AXI_BRESP), 32'(e.resp));
               end
            end
            if (S_AXI_RVALID && S_AXI_RREADY) begin
               if (rq.size() == 0) fail_now("unexpected_R");
               else begin
                  e = rq.pop_front();
                  chk("RRESP", 32'(S_AXI_RRESP), 32'(e.resp));
                  chk("RDATA", S_AXI_RDATA, e.data);
               end
            end
         end
      end
   end

   task automatic set_pins(input logic [31:0] v);
      gpio_io_i = v;
      m_pins    = v;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic drive_aw_w(input logic [8:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int skew, output bit ok);
      bit aw_done, w_done, hs_aw, hs_w;
      int cyc;
      aw_done = 0; w_done = 0; cyc = 0;
      S_AXI_AWADDR = a; S_AXI_AWVALID = 1'b1;
      S_AXI_WDATA = d; S_AXI_WSTRB = s;
      while (!(aw_done && w_done) && cyc < 50) begin
         if (cyc >= skew && !w_done) S_AXI_WVALID = 1'b1;
         @(negedge clk);
         hs_aw = S_AXI_AWVALID && S_AXI_AWREADY;
         hs_w  = S_AXI_WVALID && S_AXI_WREADY;
         @(posedge clk); #1;
         if (hs_aw) begin aw_done = 1; S_AXI_AWVALID = 1'b0; end
         if (hs_w)  begin w_done = 1;  S_AXI_WVALID = 1'b0; end
         cyc++;
      end
      ok = aw_done && w_done;
      if (!ok) begin
         S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
         fail_now("write_handshake_timeout");
      end
   endtask

   task automatic axi_write(input logic [8:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int skew, input int bdly, input bit lat);
      rsp_t e;
      bit ok;
      int t;
      e.resp = model_write(a, d, s);
      e.data = 32'h0;
      bq.push_back(e);
      S_AXI_BREADY = (bdly == 0);
      drive_aw_w(a, d, s, skew, ok);
      if (!ok) begin bq.delete(); return; end
      if (lat) begin
         @(negedge clk); chk("bvalid_early", 32'(S_AXI_BVALID), 32'h0);
         @(negedge clk); chk("bvalid_latency", 32'(S_AXI_BVALID), 32'h1);
      end
      if (bdly > 0) begin
         @(posedge clk); #1;
         for (int i = 0; i < bdly; i++) begin
            @(negedge clk);
            chk("bvalid_hold", 32'(S_AXI_BVALID), 32'h1);
            chk("bresp_hold", 32'(S_AXI_BRESP), 32'(e.resp));
            chk("awready_in_resp", 32'(S_AXI_AWREADY), 32'h0);
            chk("wready_in_resp", 32'(S_AXI_WREADY), 32'h0);
         end
         @(posedge clk); #1;
         S_AXI_BREADY = 1'b1;
      end
      t = 0;
      while (bq.size() != 0 && t < 20) begin @(posedge clk); t++; end
      if (bq.size() != 0) begin fail_now("B_timeout"); bq.delete(); end
      #1;
      chk("gpio_io_o", gpio_io_o, m_out);
   endtask

   task automatic axi_read(input logic [8:0] a, input int rdly);
      rsp_t e;
      bit done, hs;
      int t;
      e = model_read(a);
      rq.push_back(e);
      S_AXI_RREADY = (rdly == 0);
      S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1;
      done = 0; t = 0;
      while (!done && t < 50) begin
         @(negedge clk);
         hs = S_AXI_ARVALID && S_AXI_ARREADY;
         @(posedge clk); #1;
         if (hs) begin done = 1; S_AXI_ARVALID = 1'b0; end
         t++;
      end
      if (!done) begin
         S_AXI_ARVALID = 1'b0; rq.delete();
         fail_now("AR_timeout");
         return;
      end
      if (rdly > 0) begin
         t = 0;
         @(negedge clk);
         while (!S_AXI_RVALID && t < 10) begin @(negedge clk); t++; end
         for (int i = 0; i < rdly; i++) begin
            chk("rvalid_hold", 32'(S_AXI_RVALID), 32'h1);
            chk("rdata_hold", S_AXI_RDATA, e.data);
            chk("rresp_hold", 32'(S_AXI_RRESP), 32'(e.resp));
            @(negedge clk);
         end
         @(posedge clk); #1;
         S_AXI_RREADY = 1'b1;
      end
      t = 0;
      while (rq.size() != 0 && t < 20) begin @(posedge clk); t++; end
      if (rq.size() != 0) begin fail_now("R_timeout"); rq.delete(); end
      #1;
   endtask

   function automatic logic [8:0] rand_addr();
      logic [8:0] a;
      case ($urandom_range(0, 5))
         0: a = 9'h000;
         1: a = 9'h004;
         2: a = 9'h008;
         3: a = 9'h00C;
         default: a = 9'(16 + $urandom_range(0, 495));
      endcase
      if (a < 9'h010) a = a | 9'($urandom_range(0, 3));
      return a;
   endfunction

   initial begin
      bit ok;
      S_AXI_ARESET = 1'b1;
      S_AXI_AWADDR = '0; S_AXI_AWVALID = 0; S_AXI_WDATA = '0; S_AXI_WSTRB = '0;
      S_AXI_WVALID = 0; S_AXI_BREADY = 1; S_AXI_ARADDR = '0; S_AXI_ARVALID = 0;
      S_AXI_RREADY = 1; gpio_io_i = '0;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_awready", 32'(S_AXI_AWREADY), 32'h0);
      chk("rst_wready", 32'(S_AXI_WREADY), 32'h0);
      chk("rst_arready", 32'(S_AXI_ARREADY), 32'h0);
      chk("rst_bvalid", 32'(S_AXI_BVALID), 32'h0);
      chk("rst_rvalid", 32'(S_AXI_RVALID), 32'h0);
      chk("rst_rdata", S_AXI_RDATA, 32'h0);
      chk("rst_gpio", gpio_io_o, 32'h0);
      S_AXI_ARESET = 1'b0;
      @(negedge clk); chk("awready_before_edge", 32'(S_AXI_AWREADY), 32'h0);
      @(posedge clk); #1;
      chk("awready_after_release", 32'(S_AXI_AWREADY), 32'h1);
      chk("arready_after_release", 32'(S_AXI_ARREADY), 32'h1);

      axi_write(9'h000, 32'hA5A5A5A5, 4'hF, 0, 0, 1);
      set_pins(32'h12345678);
      axi_read(9'h004, 0);
      axi_write(9'h000, 32'hA5A5A5A0, 4'hF, 0, 0, 0);
      axi_write(9'h008, 32'h0000000F, 4'h1, 3, 0, 0);
      chk("set_result", gpio_io_o, 32'hA5A5A5AF);
      axi_write(9'h000, 32'h00000000, 4'hF, 0, 0, 0);
      axi_write(9'h000, 32'hFFFFFFFF, 4'h3, 0, 0, 0);
      chk("strb_result", gpio_io_o, 32'h0000FFFF);
      axi_write(9'h00C, 32'h000000FF, 4'hF, 1, 0, 0);
      chk("clr_result", gpio_io_o, 32'h0000FF00);
      axi_write(9'h000, 32'h5A5A1234, 4'hF, 0, 5, 0);
      axi_write(9'h004, 32'hDEADBEEF, 4'hF, 0, 0, 0);
      axi_read(9'h100, 0);
      axi_read(9'h000, 3);
      axi_read(9'h008, 0);
      axi_read(9'h00C, 0);
      axi_write(9'h014, 32'hFFFFFFFF, 4'hF, 0, 2, 0);

      for (int n = 0; n < 60; n++) begin
         set_pins($urandom);
         if ($urandom_range(0, 1) == 0)
            axi_write(rand_addr(), $urandom, 4'($urandom_range(0, 15)),
                      $urandom_range(0, 3), $urandom_range(0, 2), 0);
         else
            axi_read(rand_addr(), $urandom_range(0, 2));
      end

      // Reset while a write response is waiting for BREADY.
      S_AXI_BREADY = 1'b0;
      void'(model_write(9'h000, 32'hCAFEF00D, 4'hF));
      drive_aw_w(9'h000, 32'hCAFEF00D, 4'hF, 0, ok);
      @(posedge clk); #1;
      @(negedge clk);
      chk("bvalid_before_reset", 32'(S_AXI_BVALID), 32'h1);
      chk("gpio_before_reset", gpio_io_o, 32'hCAFEF00D);
      #2;
      S_AXI_ARESET = 1'b1;
      #1;
      chk("bvalid_async_clear", 32'(S_AXI_BVALID), 32'h0);
      chk("gpio_async_reset", gpio_io_o, 32'h0);
      chk("awready_in_reset", 32'(S_AXI_AWREADY), 32'h0);
      m_out = 32'h0;
      @(posedge clk); #1;
      S_AXI_ARESET = 1'b0;
      S_AXI_BREADY = 1'b1;
      @(posedge clk); #1;
      chk("awready_first_edge", 32'(S_AXI_AWREADY), 32'h1);
      chk("wready_first_edge", 32'(S_AXI_WREADY), 32'h1);
      chk("bvalid_after_reset", 32'(S_AXI_BVALID), 32'h0);

      set_pins(32'h0F0F1E1E);
      axi_read(9'h004, 0);
      axi_read(9'h000, 0);
      axi_write(9'h008, 32'h80000001, 4'h9, 0, 0, 0);

      repeat (5) @(posedge clk);
      if (bq.size() != 0 || rq.size() != 0) fail_now("leftover_expectations");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/axil_gpio_slave.md
AXIL_GPIO_SLAVE -- requirements
Module: axil_gpio_slave

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, AXI4-Lite data width (only 32 supported).
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 9, AXI4-Lite byte-address width.
REQ-003 SHALL have parameter C_GPIO_RESET, default 32'h0, reset value of gpio_io_o.
REQ-004 SHALL have port S_AXI_ACLK  in  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port S_AXI_ARESET  in  1  asynchronous, active-high reset.
REQ-006 SHALL have write-address ports: S_AXI_AWADDR in ADDR_W; S_AXI_AWVALID in 1; S_AXI_AWREADY out 1.
REQ-007 SHALL have write-data ports: S_AXI_WDATA in 32; S_AXI_WSTRB in 4; S_AXI_WVALID in 1; S_AXI_WREADY out 1.
REQ-008 SHALL have write-response ports: S_AXI_BRESP out 2; S_AXI_BVALID out 1; S_AXI_BREADY in 1.
REQ-009 SHALL have read-address ports: S_AXI_ARADDR in ADDR_W; S_AXI_ARVALID in 1; S_AXI_ARREADY out 1.
REQ-010 SHALL have read-data ports: S_AXI_RDATA out 32; S_AXI_RRESP out 2; S_AXI_RVALID out 1; S_AXI_RREADY in 1.
REQ-011 SHALL have gpio_io_o out 32 (output register) and gpio_io_i in 32 (asynchronous pins).

Function
REQ-012 SHALL decode ADDR[3:2]; ADDR above 0x0F is unmapped; ADDR[1:0] is ignored.
REQ-013 SHALL implement the map: 0x00 OUT (RW, drives gpio_io_o), 0x04 IN (RO, sampled pins), 0x08 SET (WO, write-1-sets OUT bits), 0x0C CLR (WO, write-1-clears OUT bits); SET/CLR read 0.
REQ-014 SHALL honour WSTRB per byte on OUT, SET and CLR; writes to IN are ignored with OKAY.
REQ-015 SHALL accept AW and W independently: AWREADY is high while no address is latched and no B is pending; WREADY likewise for data.
REQ-016 SHALL use write FSM W_IDLE -> W_RESP once both address and data are latched; the register update and BVALID assertion occur on the clock edge after the later handshake.
REQ-017 SHALL hold BVALID and BRESP stable until BREADY; W_RESP -> W_IDLE on the BVALID&&BREADY edge; AWREADY/WREADY stay low in W_RESP.
REQ-018 SHALL use read FSM R_IDLE (ARREADY=1) -> R_DATA on the AR handshake, registering RDATA/RRESP with RVALID on the next edge; R_DATA -> R_IDLE on RVALID&&RREADY.
REQ-019 SHALL hold RDATA/RRESP stable while RVALID && !RREADY.
REQ-020 SHALL return RRESP/BRESP 2'b10 (SLVERR) for unmapped addresses, with RDATA 0 and no register change; OKAY (2'b00) otherwise.
REQ-021 SHALL make read and write channels fully concurrent; a read of OUT on the same edge as a write returns the pre-write value.

Reset
REQ-022 SHALL, on S_AXI_ARESET high, immediately clear AWREADY, WREADY, BVALID, ARREADY, RVALID, BRESP, RRESP and RDATA, set gpio_io_o to C_GPIO_RESET, clear the input sampler, and return both FSMs to idle.
REQ-023 SHALL discard any partially latched transaction on reset; ARREADY/AWREADY/WREADY rise on the first clock edge after release.

Configuration
REQ-024 SHALL, with GPIO_INPUT_SYNC_EN defined, pass gpio_io_i through a 2-flop synchronizer, giving 2-cycle pin-to-IN latency.
REQ-025 SHALL, without GPIO_INPUT_SYNC_EN, sample gpio_io_i with a single register, giving 1-cycle pin-to-IN latency.

Structure
REQ-026 SHALL place register offsets, the RESP_OKAY/RESP_SLVERR constants and the FSM state enums in package axil_gpio_pkg.
REQ-027 SHALL isolate the input synchronizer in sub-module gpio_sync (parameterised width and stage count).

Verification
REQ-028 SHALL check: AW+W same cycle, addr 0x00, data 0xA5A5A5A5, WSTRB 0xF -> gpio_io_o=0xA5A5A5A5, BRESP=00, BVALID one cycle after handshake.
REQ-029 SHALL check: gpio_io_i=0x12345678, then read 0x04 -> RDATA=0x12345678, RRESP=00 (allow 1 or 2 sample cycles per macro).
REQ-030 SHALL check: AW at 0x08 presented 3 cycles before W (0x0000000F, WSTRB 0x1) with OUT=0xA5A5A5A0 -> OUT=0xA5A5A5AF, exactly one BVALID.
REQ-031 SHALL check: write 0x00 data 0xFFFFFFFF WSTRB 0x3 with OUT=0 -> OUT=0x0000FFFF; then CLR 0x000000FF -> OUT=0x0000FF00.
REQ-032 SHALL check: BREADY held low for 5 cycles -> BVALID/BRESP stable, AWREADY=WREADY=0; unmapped read 0x100 -> RRESP=10, RDATA=0.
REQ-033 SHALL check: S_AXI_ARESET asserted while in W_RESP -> BVALID drops immediately, gpio_io_o=C_GPIO_RESET, AWREADY high on the first clock after release.
